// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
// Size decoding lives here so the aligner and the sequencer agree on it.
package lsu_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    // Access size in bytes; the illegal code maps to 0 so it produces an empty mask.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 4'd1;
            SZ_H:    size_bytes = 4'd2;
            SZ_W:    size_bytes = 4'd4;
            default: size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment datapath: split detection, two-beat byte mask,
// two-beat store data, and merge of returned read words back to offset 0.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]          size_i,
    input  logic [1:0]          off_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [2*DATA_W-1:0] rd64_i,
    output logic                split_o,
    output logic [2*BE_W-1:0]   m8_o,
    output logic [2*DATA_W-1:0] w64_o,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [3:0] nbytes;
    logic [7:0] base_mask;
    logic [5:0] bit_off;

    assign nbytes    = size_bytes(size_i);
    assign base_mask = (8'd1 << nbytes) - 8'd1;
    assign bit_off   = {1'b0, off_i, 3'b000};

    assign split_o = ({2'b00, off_i} + nbytes) > 4'd4;
    assign m8_o    = base_mask << off_i;
    assign w64_o   = {{DATA_W{1'b0}}, wdata_i} << bit_off;
    assign rdata_o = DATA_W'(rd64_i >> bit_off);

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: latches one command, issues one or two word-aligned
// bus beats over req/ack, and returns the merged load word right-aligned.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     ivalid,
    input  logic                     iwe,
    input  logic [2:0]               ifunct3,
    input  logic [MP_DATA_WIDTH-1:0] iaddr,
    input  logic [MP_DATA_WIDTH-1:0] iwdata,
    output logic                     obusy,
    output logic                     odone,
    output logic                     oerr,
    output logic [MP_DATA_WIDTH-1:0] ordata,
    output logic                     omem_req,
    output logic                     omem_we,
    output logic [MP_DATA_WIDTH-1:0] omem_addr,
    output logic [MP_DATA_WIDTH-1:0] omem_wdata,
    output logic [BE_W-1:0]          omem_be,
    input  logic                     imem_ack,
    input  logic [MP_DATA_WIDTH-1:0] imem_rdata
);

    state_e              state_q;
    logic [1:0]          off_q;
    logic                split_q;
    logic                we_q;
    logic [DATA_W-1:0]   rd0_q;
    logic [DATA_W-1:0]   addr2_q;
    logic [BE_W-1:0]     be2_q;
    logic [DATA_W-1:0]   wdata2_q;

    logic                obusy_q, odone_q, oerr_q;
    logic [DATA_W-1:0]   ordata_q;
    logic                req_q, mwe_q;
    logic [DATA_W-1:0]   maddr_q, mwdata_q;
    logic [BE_W-1:0]     mbe_q;

    logic                split;
    logic [2*BE_W-1:0]   m8;
    logic [2*DATA_W-1:0] w64;
    logic [DATA_W-1:0]   merged;
    logic [1:0]          off_sel;
    logic [2*DATA_W-1:0] rd64;
    logic [DATA_W-1:0]   word_addr;

    // Sign extension is the downstream load decoder's job; only size matters here.
    logic unused_sign;
    assign unused_sign = ifunct3[2];

    assign word_addr = {iaddr[DATA_W-1:2], 2'b00};
    // Live offset while accepting, latched offset while merging returned data.
    assign off_sel   = (state_q == IDLE) ? iaddr[1:0] : off_q;
    assign rd64      = (state_q == ACC1) ? {imem_rdata, rd0_q}
                                         : {{DATA_W{1'b0}}, imem_rdata};

    lsu_align u_align (
        .size_i  (ifunct3[1:0]),
        .off_i   (off_sel),
        .wdata_i (iwdata),
        .rd64_i  (rd64),
        .split_o (split),
        .m8_o    (m8),
        .w64_o   (w64),
        .rdata_o (merged)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q  <= IDLE;
            off_q    <= 2'b00;
            split_q  <= 1'b0;
            we_q     <= 1'b0;
            rd0_q    <= '0;
            addr2_q  <= '0;
            be2_q    <= '0;
            wdata2_q <= '0;
            obusy_q  <= 1'b0;
            odone_q  <= 1'b0;
            oerr_q   <= 1'b0;
            ordata_q <= '0;
            req_q    <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mbe_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ivalid) begin
                        obusy_q <= 1'b1;
                        off_q   <= iaddr[1:0];
                        we_q    <= iwe;
                        split_q <= split;
                        if (ifunct3[1:0] == SZ_ILL) begin
                            oerr_q  <= 1'b1;
                            odone_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            oerr_q   <= 1'b0;
                            req_q    <= 1'b1;
                            mwe_q    <= iwe;
                            maddr_q  <= word_addr;
                            mbe_q    <= m8[BE_W-1:0];
                            mwdata_q <= w64[DATA_W-1:0];
                            addr2_q  <= word_addr + 32'd4;
                            be2_q    <= m8[2*BE_W-1:BE_W];
                            wdata2_q <= w64[2*DATA_W-1:DATA_W];
                            state_q  <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (imem_ack) begin
                        rd0_q <= imem_rdata;
                        if (split_q) begin
                            // Request stays high and flips straight to the second beat.
                            maddr_q  <= addr2_q;
                            mbe_q    <= be2_q;
                            mwdata_q <= wdata2_q;
                            state_q  <= ACC1;
                        end else begin
                            req_q   <= 1'b0;
                            odone_q <= 1'b1;
                            if (!we_q) ordata_q <= merged;
                            state_q <= DONE;
                        end
                    end
                end
                ACC1: begin
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        odone_q <= 1'b1;
                        if (!we_q) ordata_q <= merged;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    odone_q <= 1'b0;
                    oerr_q  <= 1'b0;
                    obusy_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign obusy      = obusy_q;
    assign odone      = odone_q;
    assign oerr       = oerr_q;
    assign ordata     = ordata_q;
    assign omem_req   = req_q;
    assign omem_we    = mwe_q;
    assign omem_addr  = maddr_q;
    assign omem_wdata = mwdata_q;
    assign omem_be    = mbe_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Scoreboard bench for lsu_seq: stimulus pushes expected bus beats and
// completions; a bus responder and a completion monitor pop and compare.
module tb_lsu_seq;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        ivalid = 1'b0;
    logic        iwe = 1'b0;
    logic [2:0]  ifunct3 = 3'b000;
    logic [31:0] iaddr = '0;
    logic [31:0] iwdata = '0;
    logic        obusy, odone, oerr;
    logic [31:0] ordata;
    logic        omem_req, omem_we;
    logic [31:0] omem_addr, omem_wdata;
    logic [3:0]  omem_be;
    logic        imem_ack;
    logic        rsp_ack = 1'b0;
    logic        late_ack = 1'b0;
    logic [31:0] imem_rdata = '0;

    assign imem_ack = rsp_ack | late_ack;

    lsu_seq #(.MP_DATA_WIDTH(32)) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ivalid     (ivalid),
        .iwe        (iwe),
        .ifunct3    (ifunct3),
        .iaddr      (iaddr),
        .iwdata     (iwdata),
        .obusy      (obusy),
        .odone      (odone),
        .oerr       (oerr),
        .ordata     (ordata),
        .omem_req   (omem_req),
        .omem_we    (omem_we),
        .omem_addr  (omem_addr),
        .omem_wdata (omem_wdata),
        .omem_be    (omem_be),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    int ntests = 0;
    int nfail  = 0;
    int wcnt   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bus responder / beat monitor
    initial begin
        beat_t b;
        forever begin
            @(negedge iclk);
            rsp_ack = 1'b0;
            if (!irst_n) begin
                wcnt = 0;
            end else if (omem_req) begin
                if (beat_q.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_req: got addr %h, no beat expected", omem_addr);
                    rsp_ack = 1'b1;
                end else if (wcnt < beat_q[0].waits) begin
                    wcnt++;
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_addr", omem_addr, b.addr);
                    chk("beat_we", {31'd0, omem_we}, {31'd0, b.we});
                    chk("beat_be", {28'd0, omem_be}, {28'd0, b.be});
                    if (b.we) chk("beat_wdata", omem_wdata, b.wdata);
                    imem_rdata = b.rdata;
                    rsp_ack    = 1'b1;
                    wcnt       = 0;
                end
            end
        end
    end

    // Completion monitor
    initial begin
        done_t d;
        forever begin
            @(negedge iclk);
            if (irst_n && odone) begin
                if (done_q.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_done: got odone=1 at cycle %0d, none expected", cyc);
                end else begin
                    d = done_q.pop_front();
                    chk("oerr", {31'd0, oerr}, {31'd0, d.err});
                    chk("ordata", ordata, d.rdata);
                    chk("done_cycle", cyc, d.cyc);
                    chk("busy_at_done", {31'd0, obusy}, 32'd1);
                end
            end
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic we, input logic [3:0] be,
                             input logic [31:0] wd, input logic [31:0] rd, input int waits);
        beat_t b;
        b.addr = a; b.we = we; b.be = be; b.wdata = wd; b.rdata = rd; b.waits = waits;
        beat_q.push_back(b);
    endtask

    // Presents one command for a single cycle, then scrambles the inputs to prove latching.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic err,
                         input logic [31:0] exp_rd, input bit expect_done);
        done_t d;
        @(negedge iclk);
        ivalid = 1'b1; iwe = we; ifunct3 = f3; iaddr = a; iwdata = wd;
        if (expect_done) begin
            d.err = err; d.rdata = exp_rd; d.cyc = cyc + lat;
            done_q.push_back(d);
        end
        @(posedge iclk);
        #1;
        ivalid = 1'b0; iwe = ~we; ifunct3 = 3'b011; iaddr = ~a; iwdata = ~wd;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge iclk);
        while (obusy && n < 100) begin
            @(negedge iclk);
            n++;
        end
        ntests++;
        if (obusy) begin
            nfail++;
            $display("FAIL %s_timeout: got obusy=1 after %0d cycles, expected idle", name, n);
        end
        chk({name, "_beats_left"}, beat_q.size(), 32'd0);
        chk({name, "_dones_left"}, done_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge iclk);
        chk("rst_req", {31'd0, omem_req}, 32'd0);
        chk("rst_busy", {31'd0, obusy}, 32'd0);
        chk("rst_done", {31'd0, odone}, 32'd0);
        chk("rst_err", {31'd0, oerr}, 32'd0);
        chk("rst_ordata", ordata, 32'd0);
        chk("rst_addr", omem_addr, 32'd0);
        chk("rst_be", {28'd0, omem_be}, 32'd0);
        irst_n = 1'b1;

        // Aligned lw, two wait states
        push_beat(32'h0000_0100, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 4, 1'b0, 32'hDEAD_BEEF, 1'b1);

        // A command offered during the DONE cycle must be dropped
        n = 0;
        @(negedge iclk);
        while (!odone && n < 20) begin
            @(negedge iclk);
            n++;
        end
        chk("saw_done_lw", {31'd0, odone}, 32'd1);
        ivalid = 1'b1; ifunct3 = 3'b011;
        @(posedge iclk);
        #1 ivalid = 1'b0;
        @(negedge iclk);
        chk("valid_in_done_busy", {31'd0, obusy}, 32'd0);
        chk("valid_in_done_odone", {31'd0, odone}, 32'd0);
        @(negedge iclk);
        chk("valid_in_done_busy2", {31'd0, obusy}, 32'd0);

        // Split lw at 0x103
        push_beat(32'h0000_0100, 1'b0, 4'b1000, 32'h0, 32'h4433_2211, 0);
        push_beat(32'h0000_0104, 1'b0, 4'b0111, 32'h0, 32'h8877_6655, 0);
        issue(1'b0, 3'b010, 32'h0000_0103, 32'h0, 3, 1'b0, 32'h7766_5544, 1'b1);
        wait_idle("lw_split");

        // Split sh at 0x0FFFFFFF, one wait on the first beat; ordata holds
        push_beat(32'h0FFF_FFFC, 1'b1, 4'b1000, 32'hCD00_0000, 32'h0, 1);
        push_beat(32'h1000_0000, 1'b1, 4'b0001, 32'h0000_00AB, 32'h0, 0);
        issue(1'b1, 3'b001, 32'h0FFF_FFFF, 32'h0000_ABCD, 4, 1'b0, 32'h7766_5544, 1'b1);
        wait_idle("sh_split");

        // lbu at offset 2
        push_beat(32'h0000_0200, 1'b0, 4'b0100, 32'h0, 32'h1122_3344, 0);
        issue(1'b0, 3'b100, 32'h0000_0202, 32'h0, 2, 1'b0, 32'h0000_1122, 1'b1);
        wait_idle("lbu");

        // lh at offset 3 splits
        push_beat(32'h0000_0200, 1'b0, 4'b1000, 32'h0, 32'hAABB_CCDD, 0);
        push_beat(32'h0000_0204, 1'b0, 4'b0001, 32'h0, 32'h0000_0011, 0);
        issue(1'b0, 3'b001, 32'h0000_0203, 32'h0, 3, 1'b0, 32'h0000_11AA, 1'b1);
        wait_idle("lh_split");

        // Illegal size: immediate error, no bus traffic, stray ack ignored
        issue(1'b0, 3'b011, 32'h0000_0300, 32'h0, 1, 1'b1, 32'h0000_11AA, 1'b1);
        late_ack = 1'b1;
        @(posedge iclk);
        #1 late_ack = 1'b0;
        wait_idle("illegal");

        // sb at offset 1
        push_beat(32'h0000_0000, 1'b1, 4'b0010, 32'h0000_5A00, 32'h0, 0);
        issue(1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 2, 1'b0, 32'h0000_11AA, 1'b1);
        wait_idle("sb");

        // sw at 0xFFFFFFFE: second beat wraps; reset while it waits for ack
        push_beat(32'hFFFF_FFFC, 1'b1, 4'b1100, 32'h5678_0000, 32'h0, 0);
        push_beat(32'h0000_0000, 1'b1, 4'b0011, 32'h0000_1234, 32'h0, 1000);
        issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1234_5678, 0, 1'b0, 32'h0, 1'b0);
        n = 0;
        @(negedge iclk);
        while (!(omem_req && omem_be == 4'b0011) && n < 20) begin
            @(negedge iclk);
            n++;
        end
        chk("wrap_addr", omem_addr, 32'h0000_0000);
        chk("wrap_wdata", omem_wdata, 32'h0000_1234);
        chk("wrap_req", {31'd0, omem_req}, 32'd1);
        #2 irst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, omem_req}, 32'd0);
        chk("async_rst_busy", {31'd0, obusy}, 32'd0);
        beat_q.delete();
        done_q.delete();
        @(negedge iclk);
        @(negedge iclk);
        irst_n = 1'b1;
        chk("post_rst_ordata", ordata, 32'd0);
        late_ack = 1'b1;
        @(negedge iclk);
        late_ack = 1'b0;
        chk("late_ack_busy", {31'd0, obusy}, 32'd0);
        chk("late_ack_done", {31'd0, odone}, 32'd0);
        @(negedge iclk);
        chk("late_ack_busy2", {31'd0, obusy}, 32'd0);

        // Normal load after recovery
        push_beat(32'h0000_0000, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D, 0);
        issue(1'b0, 3'b010, 32'h0000_0000, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 1'b1);
        wait_idle("lw_after_rst");

        repeat (2) @(negedge iclk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Load/store sequencer between the execute stage and the data-memory bus. It accepts one load or store command at a time and issues one or two word-aligned bus transactions over a req/ack handshake. Misaligned accesses that cross a word boundary are split into two transactions, and the read data is merged. The returned load word is right-aligned to byte 0, so the downstream load decoder always runs with offset 2'b00.

## Interface
Parameters:
- MP_DATA_WIDTH, 32, data and address width; only 32 is supported.

Ports:
- iclk  in  1  clock, rising edge.
- irst_n  in  1  reset; asynchronous assertion, active-low.
- ivalid  in  1  command strobe; sampled only in IDLE.
- iwe  in  1  1 = store, 0 = load.
- ifunct3  in  3  size and sign; [1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- iaddr  in  32  byte address.
- iwdata  in  32  store data, LSB-aligned.
- obusy  out  1  high from accept until the odone cycle inclusive.
- odone  out  1  one-cycle completion pulse.
- oerr  out  1  valid with odone; 1 = illegal size.
- ordata  out  32  merged load word at offset 0; valid with odone; held until the next odone.
- omem_req  out  1  bus request.
- omem_we  out  1  bus write.
- omem_addr  out  32  word address, [1:0] = 00.
- omem_wdata  out  32  bus write data.
- omem_be  out  4  byte enables; also qualify reads.
- imem_ack  in  1  transaction complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  bus read data.

## Operation
- Notation: off = iaddr[1:0]; sz = 1, 2 or 4 bytes from ifunct3[1:0].
- Split condition: off + sz > 4. This covers a word at off≠0 and a half at off=3. Bytes never split.
- Byte-enable mask: m8 = ((1<<sz)-1) << off, 8 bits wide.
  - First beat uses m8[3:0]; second beat uses m8[7:4].
- Store data: w64 = iwdata << 8*off, 64 bits wide.
  - First beat uses w64[31:0]; second beat uses w64[63:32].
- Addresses:
  - First beat: {iaddr[31:2],2'b00}.
  - Second beat: first + 4, modulo 2^32. Address 0xFFFFFFFC wraps to 0x00000000.
- Load merge: ordata = ({rd1,rd0} >> 8*off)[31:0]. rd1 = 0 when the access is not split.
- Latching: command fields are latched on accept; input changes after accept are ignored.
- State machine, registered:
  - IDLE: obusy=0. If ivalid and size is legal, go to ACC0. If ivalid and size is illegal, go to DONE with oerr=1 and no bus access.
  - ACC0: omem_req=1 with first-beat fields. On imem_ack, capture rd0, then go to ACC1 if split, else DONE.
  - ACC1: omem_req=1 with second-beat fields. On imem_ack, capture rd1, then go to DONE.
  - DONE: odone=1 and ordata updated; return to IDLE.
- Bus handshake:
  - Address, we, wdata and be are stable while omem_req=1 and until imem_ack.
  - omem_req drops in the cycle after the ack, or switches directly to the second-beat fields.
  - imem_ack while omem_req=0 is ignored.
- Stores leave ordata unchanged.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset mid-operation:
  - omem_req deasserts asynchronously and the command is abandoned.
  - No odone is issued.
  - A late imem_ack after reset release is ignored.
- Latency: ivalid at cycle t gives omem_req at t+1.
  - With ack at t+1, odone is at t+2.
  - A split access with zero-wait acks gives odone at t+3.
  - Each wait state adds 1 cycle.
- ivalid during a DONE cycle is ignored; a new command is accepted only in IDLE, i.e. at t+3 at the earliest.
- An illegal size gives odone/oerr at t+1.

## Structure
- Package lsu_pkg holds:
  - state enum {IDLE, ACC0, ACC1, DONE};
  - size codes SZ_B/SZ_H/SZ_W/SZ_ILL;
  - widths (DATA_W, BE_W=4).
- Sub-module lsu_align, combinational, computes:
  - split flag;
  - m8;
  - w64;
  - load merge from {rd1,rd0} and off.
- The FSM, latch registers and bus drivers stay in lsu_seq.

## Test plan
- Aligned lw at 0x100, ack after 2 waits with rdata 0xDEADBEEF → one request, be=1111, ordata 0xDEADBEEF, odone at t+4.
- Load word at 0x103 with rdata 0x44332211 then 0x88776655 → addr 0x100 then 0x104, be 1000 then 0111, ordata 0x77665544.
- Store half 0xABCD at 0x0FFFFFFF → first beat addr 0x0FFFFFFC be 1000 wdata 0xCD000000; second beat addr 0x10000000 be 0001 wdata 0x000000AB.
- Store word at 0xFFFFFFFE → second beat addr wraps to 0x00000000, be 0011.
- ifunct3=011 → oerr=1 with odone at t+1, omem_req never asserted.
- irst_n low while in ACC1 waiting for ack → omem_req=0 immediately, no odone; next command after release completes normally.
